// File: rtl/sdram_local_arbiter.sv
// Two-port round-robin arbiter in front of an SDRAM controller local interface.
// Writes hold the grant for the whole burst; reads issue a single command and
// leave a {requester, size} tag so returning data can be steered back.
module sdram_local_arbiter #(
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic        phy_clk,
  input  logic        reset_phy_clk,
  input  logic [20:0] p0_address,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [2:0]  p0_size,
  input  logic        p0_burstbegin,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_ready,
  output logic [31:0] p0_rdata,
  output logic        p0_rdata_valid,
  input  logic [20:0] p1_address,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [2:0]  p1_size,
  input  logic        p1_burstbegin,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_ready,
  output logic [31:0] p1_rdata,
  output logic        p1_rdata_valid,
  output logic [20:0] local_address,
  output logic        local_read_req,
  output logic        local_write_req,
  output logic [2:0]  local_size,
  output logic        local_burstbegin,
  output logic [31:0] local_wdata,
  output logic [3:0]  local_be,
  input  logic        local_ready,
  input  logic [31:0] local_rdata,
  input  logic        local_rdata_valid,
  input  logic        local_init_done,
  output logic        rd_orphan_err
);

  localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [2:0]    beat_cnt_q, beat_cnt_d;
  logic [2:0]    len_q, len_d;
  logic [2:0]    ret_cnt_q, ret_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          orphan_q, orphan_d;

  logic          tag_id_mem [TAG_DEPTH];
  logic [2:0]    tag_sz_mem [TAG_DEPTH];

  logic          g_read, g_write, g_burstbegin;
  logic [2:0]    g_size, g_eff_size, cur_len;
  logic          fifo_full, fifo_empty, push, pop, g_ready, rd_stall;
  logic          head_id;
  logic [2:0]    head_sz;

  assign g_read       = grant_q ? p1_read : p0_read;
  assign g_write      = grant_q ? p1_write : p0_write;
  assign g_burstbegin = grant_q ? p1_burstbegin : p0_burstbegin;
  assign g_size       = grant_q ? p1_size : p0_size;
  assign g_eff_size   = (g_size == 3'd0) ? 3'd1 : g_size;
  assign cur_len      = (beat_cnt_q == 3'd0) ? g_eff_size : len_q;

  assign fifo_full  = (count_q == (PW+1)'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_id    = tag_id_mem[rd_ptr_q];
  assign head_sz    = tag_sz_mem[rd_ptr_q];
  assign rd_stall   = g_read & ~g_write & fifo_full;

  assign p0_rdata      = local_rdata;
  assign p1_rdata      = local_rdata;
  assign rd_orphan_err = orphan_q;

  // Arbitration FSM, command mirroring and burst/beat tracking
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    beat_cnt_d       = beat_cnt_q;
    len_d            = len_q;
    push             = 1'b0;
    local_address    = grant_q ? p1_address : p0_address;
    local_size       = g_size;
    local_wdata      = grant_q ? p1_wdata : p0_wdata;
    local_be         = grant_q ? p1_be : p0_be;
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    g_ready          = 1'b0;
    unique case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (local_init_done && (p0_read || p0_write || p1_read || p1_write)) begin
          if ((p0_read || p0_write) && (p1_read || p1_write)) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = p1_read || p1_write;
          end
          last_grant_d = grant_d;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        local_write_req  = g_write & local_init_done;
        local_read_req   = g_read & ~g_write & ~fifo_full & local_init_done;
        local_burstbegin = g_burstbegin & local_init_done;
        g_ready          = local_ready & local_init_done & ~rd_stall;
        if (beat_cnt_q == 3'd0 && !g_read && !g_write) begin
          state_d = IDLE;
        end else if (local_write_req && local_ready) begin
          if (beat_cnt_q == 3'd0) len_d = g_eff_size;
          if (beat_cnt_q + 3'd1 == cur_len) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end else if (beat_cnt_q == 3'd0 && local_read_req && local_ready) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    p0_ready = g_ready & ~grant_q;
    p1_ready = g_ready & grant_q;
  end

  // Read return steering, tag FIFO bookkeeping and orphan detection
  always_comb begin
    pop            = 1'b0;
    ret_cnt_d      = ret_cnt_q;
    orphan_d       = orphan_q | (local_rdata_valid & fifo_empty);
    p0_rdata_valid = local_rdata_valid & ~fifo_empty & ~head_id;
    p1_rdata_valid = local_rdata_valid & ~fifo_empty & head_id;
    if (local_rdata_valid && !fifo_empty) begin
      if (ret_cnt_q + 3'd1 == head_sz) begin
        pop       = 1'b1;
        ret_cnt_d = '0;
      end else begin
        ret_cnt_d = ret_cnt_q + 3'd1;
      end
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any burst in progress and all tags
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      len_q        <= 3'd1;
      ret_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      orphan_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      ret_cnt_q    <= ret_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      orphan_q     <= orphan_d;
    end
  end

  // Tag storage; contents are don't-care while the pointers mark it empty
  always_ff @(posedge phy_clk) begin
    if (push) begin
      tag_id_mem[wr_ptr_q] <= grant_q;
      tag_sz_mem[wr_ptr_q] <= g_eff_size;
    end
  end

endmodule

// File: doc/sdram_local_arbiter.md
SDRAM_LOCAL_ARBITER -- requirements
Module: sdram_local_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 8, meaning the maximum number of outstanding read commands (power of 2, 2..16).
REQ-002 SHALL have port phy_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset_phy_clk, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have, for each requester pN with N = 0, 1, the following inputs: pN_address (21 bits), pN_read (1), pN_write (1), pN_size (3), pN_burstbegin (1), pN_wdata (32) and pN_be (4).
REQ-005 SHALL have, for each requester pN, the following outputs: pN_ready (1), pN_rdata (32) and pN_rdata_valid (1).
REQ-006 SHALL have the controller-side outputs local_address (21), local_read_req (1), local_write_req (1), local_size (3), local_burstbegin (1), local_wdata (32) and local_be (4).
REQ-007 SHALL have the controller-side inputs local_ready (1), local_rdata (32), local_rdata_valid (1) and local_init_done (1).
REQ-008 SHALL have output rd_orphan_err, 1 bit: sticky flag, set when read data arrives with no outstanding tag.

Function
REQ-009 SHALL implement state machine IDLE -> BUSY -> IDLE, with state and grant held in registers.
REQ-010 In IDLE, a requester is requesting when pN_read or pN_write is high.
REQ-011 In IDLE, with local_init_done=1 and at least one requester requesting, the block SHALL load grant on the next edge and enter BUSY.
REQ-012 Arbitration in IDLE SHALL follow these rules:
- Only one requester requesting: that requester wins.
- Both requesting: the requester not equal to last_grant wins (round-robin).
- last_grant updates whenever grant is loaded.
REQ-013 While local_init_done=0 the block SHALL stay in IDLE, and all pN_ready and local_*_req outputs SHALL be 0.
REQ-014 In IDLE, local_read_req, local_write_req, local_burstbegin and both pN_ready SHALL be 0.
REQ-015 In BUSY, local_address, local_read_req, local_write_req, local_size, local_burstbegin, local_wdata and local_be SHALL combinationally mirror the granted requester's inputs; the non-granted requester's pN_ready SHALL be 0.
REQ-016 Effective burst length SHALL be pN_size sampled at the first accepted beat, with size 0 treated as 1 (range 1..7).
REQ-017 Write grant (first beat has pN_write=1):
- A beat is accepted when local_write_req & local_ready.
- A 3-bit beat counter counts accepted beats.
- The block SHALL return to IDLE on the edge after the beat that reaches the burst length.
REQ-018 Read grant:
- Accepted when local_read_req & local_ready & tag FIFO not full.
- On acceptance, push {grant, effective size} into the tag FIFO and return to IDLE.
REQ-019 While the tag FIFO is full and a read is granted, local_read_req and the granted pN_ready SHALL be 0; no command is lost.
REQ-020 pN_ready (granted requester) SHALL equal local_ready, qualified by REQ-019 for reads.
REQ-021 pN_rdata SHALL equal local_rdata for both requesters at all times.
REQ-022 pN_rdata_valid SHALL be local_rdata_valid & (FIFO head id == N) & FIFO not empty.
REQ-023 Read return SHALL be tracked as follows:
- A 3-bit return counter counts local_rdata_valid beats.
- At the beat equal to the head size, pop the head and clear the counter.
REQ-024 A simultaneous push and pop in one cycle SHALL keep the occupancy count unchanged; a push with the FIFO full never occurs per REQ-019.
REQ-025 local_rdata_valid with an empty FIFO SHALL set rd_orphan_err, assert neither pN_rdata_valid, and leave the FIFO unchanged.
REQ-026 A request deasserted by the granted requester before the first accepted beat SHALL return the block to IDLE on the next edge, with no FIFO push.
REQ-027 FIFO pointers SHALL wrap modulo TAG_DEPTH; the occupancy counter is log2(TAG_DEPTH)+1 bits.

Reset
REQ-028 Reset SHALL load the following values:
- state=IDLE.
- last_grant=1, so p0 wins the first tie.
- Beat and return counters=0.
- FIFO empty.
- rd_orphan_err=0.
- All pN_ready, pN_rdata_valid and local_*_req = 0 from the cycle after reset is sampled.
REQ-029 Reset asserted mid-burst or with reads outstanding SHALL abort the operation and discard all tags; reset has priority over every other event.

Verification
REQ-030 Both requesters issue write size=2 continuously, local_ready=1 -> grants alternate p0,p1,p0..., with 2 accepted beats per grant and one IDLE cycle between grants.
REQ-031 p1 read size=4, then p0 read size=1, then rdata_valid for 5 cycles -> p1_rdata_valid for beats 1-4, p0_rdata_valid for beat 5, FIFO empty afterwards.
REQ-032 TAG_DEPTH=8, 9 back-to-back size-1 reads with no return data -> 8 accepted; the 9th is stalled with p_ready=0 and accepted the cycle after the first rdata_valid pops a tag.
REQ-033 local_rdata_valid=1 with no reads issued -> rd_orphan_err=1 and stays 1 until reset; no pN_rdata_valid.
REQ-034 Reset pulsed after beat 1 of a size-3 write -> local_write_req=0 and state IDLE in the next cycle; the next request is granted normally.
REQ-035 local_init_done=0 with both requesters requesting -> no grant and all ready outputs 0; init_done rising -> p0 granted on the next edge.
